// File: rtl/arp_requester_if.sv
// Handshake and stream bundle for arp_requester.
// The lookup request/response pair, the outgoing ARP request stream and the
// incoming ARP reply stream travel together. The slave modport is the
// resolver's view; the master modport is the view of whoever drives it.
interface arp_requester_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_ip;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_ok;
  logic [31:0] resp_ip;
  logic [47:0] resp_mac;

  logic        axis_o_tready;
  logic        axis_o_tvalid;
  logic        axis_o_tlast;
  logic [3:0]  axis_o_tkeep;
  logic [31:0] axis_o_tdata;
  logic [47:0] axis_o_dst_mac;

  logic        axis_i_tready;
  logic        axis_i_tvalid;
  logic        axis_i_tlast;
  logic [3:0]  axis_i_tkeep;
  logic [31:0] axis_i_tdata;

  modport slave (
    input  req_valid, req_ip, resp_ready,
    input  axis_o_tready,
    input  axis_i_tvalid, axis_i_tlast, axis_i_tkeep, axis_i_tdata,
    output req_ready, resp_valid, resp_ok, resp_ip, resp_mac,
    output axis_o_tvalid, axis_o_tlast, axis_o_tkeep, axis_o_tdata, axis_o_dst_mac,
    output axis_i_tready
  );

  modport master (
    output req_valid, req_ip, resp_ready,
    output axis_o_tready,
    output axis_i_tvalid, axis_i_tlast, axis_i_tkeep, axis_i_tdata,
    input  req_ready, resp_valid, resp_ok, resp_ip, resp_mac,
    input  axis_o_tvalid, axis_o_tlast, axis_o_tkeep, axis_o_tdata, axis_o_dst_mac,
    input  axis_i_tready
  );
endinterface

// File: rtl/arp_requester.sv
// ARP initiator: resolves a next-hop IPv4 address to a MAC address.
// A lookup emits a 28-byte ARP request (broadcast), then waits for a matching
// reply, retrying after TIMEOUT_CYCLES and giving up after MAX_RETRIES
// retransmissions. The first wire octet of a beat is tdata[7:0]; multi-byte
// fields go out most significant octet first.
// Optional one-entry result cache: define ARP_REQUESTER_CACHE_EN.
module arp_requester #(
  parameter int          AXIS_BYTES     = 4,
  parameter logic [47:0] OUR_MAC        = 48'h070605040302,
  parameter logic [31:0] OUR_IP         = {8'd110, 8'd0, 8'd0, 8'd10},
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic         clk,
  input  logic         sreset,
  arp_requester_if.slave arp
);

  generate
    if (AXIS_BYTES != 4) begin : g_bad_width
      $error("arp_requester: only AXIS_BYTES = 4 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RETRY_LIMIT  = 32'(MAX_RETRIES);

  // Wire order <-> field order for a 32-bit field occupying a whole beat.
  function automatic logic [31:0] byteSwap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] target_q;
  logic [31:0] retries_q;
  logic [31:0] timer_q;
  logic [2:0]  txBeat_q;
  logic        respOk_q;
  logic [31:0] respIp_q;
  logic [47:0] respMac_q;

  logic [2:0]  rxBeat_q;
  logic        rxOk_q;
  logic [47:0] rxSha_q;

  logic        reqFire, txFire, txLastFire, timeoutHit, rxFire, rxMatch;
  logic        beatOk, rxOkNow, rxReplyOk;
  logic        cacheHit;
  logic [47:0] cacheMac;

  assign reqFire    = (state_q == IDLE) && arp.req_valid;
  assign txFire     = (state_q == SEND) && arp.axis_o_tready;
  assign txLastFire = txFire && (txBeat_q == 3'd6);
  assign timeoutHit = (state_q == WAIT) && (timer_q == TIMEOUT_LAST);
  assign rxFire     = arp.axis_i_tvalid;
  assign rxMatch    = (state_q == WAIT) && rxFire && arp.axis_i_tlast && rxReplyOk;

`ifdef ARP_REQUESTER_CACHE_EN
  logic        cacheValid_q;
  logic [31:0] cacheIp_q;
  logic [47:0] cacheMac_q;

  // Remember the most recent successful resolution
  always_ff @(posedge clk) begin
    if (sreset) begin
      cacheValid_q <= 1'b0;
      cacheIp_q    <= '0;
      cacheMac_q   <= '0;
    end else if (rxMatch) begin
      cacheValid_q <= 1'b1;
      cacheIp_q    <= target_q;
      cacheMac_q   <= rxSha_q;
    end
  end

  assign cacheHit = cacheValid_q && (cacheIp_q == arp.req_ip);
  assign cacheMac = cacheMac_q;
`else
  assign cacheHit = 1'b0;
  assign cacheMac = '0;
`endif

  // Per-beat reply checks; beats past 6 are Ethernet padding and always pass
  always_comb begin
    beatOk = 1'b1;
    case (rxBeat_q)
      3'd0: beatOk = (arp.axis_i_tkeep == 4'hF) && (arp.axis_i_tdata == 32'h00080100);
      3'd1: beatOk = (arp.axis_i_tkeep == 4'hF) && (arp.axis_i_tdata == 32'h02000406);
      3'd2: beatOk = (arp.axis_i_tkeep == 4'hF);
      3'd3: beatOk = (arp.axis_i_tkeep == 4'hF) &&
                     ({arp.axis_i_tdata[23:16], arp.axis_i_tdata[31:24]} == target_q[31:16]);
      3'd4: beatOk = (arp.axis_i_tkeep == 4'hF) &&
                     ({arp.axis_i_tdata[7:0], arp.axis_i_tdata[15:8]} == target_q[15:0]);
      3'd5: beatOk = (arp.axis_i_tkeep == 4'hF);
      3'd6: beatOk = (arp.axis_i_tkeep == 4'hF) && (byteSwap32(arp.axis_i_tdata) == OUR_IP);
      default: beatOk = 1'b1;
    endcase
    rxOkNow   = rxOk_q && beatOk;
    rxReplyOk = rxOkNow && (rxBeat_q >= 3'd6);
  end

  // Reply parser: tracks beat index and accumulated validity, captures SHA
  always_ff @(posedge clk) begin
    if (sreset) begin
      rxBeat_q <= '0;
      rxOk_q   <= 1'b1;
      rxSha_q  <= '0;
    end else if (rxFire) begin
      if (arp.axis_i_tlast) begin
        rxBeat_q <= '0;
        rxOk_q   <= 1'b1;
      end else begin
        if (rxBeat_q != 3'd7) rxBeat_q <= rxBeat_q + 3'd1;
        rxOk_q <= rxOkNow;
      end
      if (rxBeat_q == 3'd2) rxSha_q[47:16] <= byteSwap32(arp.axis_i_tdata);
      if (rxBeat_q == 3'd3) rxSha_q[15:0]  <= {arp.axis_i_tdata[7:0], arp.axis_i_tdata[15:8]};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (sreset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; a reply match takes priority over a timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (reqFire) state_d = cacheHit ? DONE : SEND;
      SEND: if (txLastFire) state_d = WAIT;
      WAIT: begin
        if (rxMatch)         state_d = DONE;
        else if (timeoutHit) state_d = (retries_q < RETRY_LIMIT) ? SEND : DONE;
      end
      DONE: if (arp.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction datapath: target, retry count, timer, tx beat and result
  always_ff @(posedge clk) begin
    if (sreset) begin
      target_q  <= '0;
      retries_q <= '0;
      timer_q   <= '0;
      txBeat_q  <= '0;
      respOk_q  <= 1'b0;
      respIp_q  <= '0;
      respMac_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqFire) begin
            target_q  <= arp.req_ip;
            retries_q <= '0;
            txBeat_q  <= '0;
            if (cacheHit) begin
              respOk_q  <= 1'b1;
              respIp_q  <= arp.req_ip;
              respMac_q <= cacheMac;
            end
          end
        end
        SEND: begin
          if (txFire) begin
            txBeat_q <= txLastFire ? 3'd0 : txBeat_q + 3'd1;
            if (txLastFire) timer_q <= '0;
          end
        end
        WAIT: begin
          timer_q <= timer_q + 32'd1;
          if (rxMatch) begin
            respOk_q  <= 1'b1;
            respIp_q  <= target_q;
            respMac_q <= rxSha_q;
          end else if (timeoutHit) begin
            if (retries_q < RETRY_LIMIT) begin
              retries_q <= retries_q + 32'd1;
              txBeat_q  <= '0;
            end else begin
              respOk_q  <= 1'b0;
              respIp_q  <= target_q;
              respMac_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM outputs and request payload mux; tdata depends only on registers
  always_comb begin
    arp.req_ready      = (state_q == IDLE);
    arp.resp_valid     = (state_q == DONE);
    arp.resp_ok        = respOk_q;
    arp.resp_ip        = respIp_q;
    arp.resp_mac       = respMac_q;
    arp.axis_o_tvalid  = (state_q == SEND);
    arp.axis_o_tlast   = (txBeat_q == 3'd6);
    arp.axis_o_tkeep   = 4'hF;
    arp.axis_o_dst_mac = 48'hFFFFFFFFFFFF;
    arp.axis_i_tready  = 1'b1;
    arp.axis_o_tdata   = '0;
    case (txBeat_q)
      3'd0: arp.axis_o_tdata = 32'h00080100;
      3'd1: arp.axis_o_tdata = 32'h01000406;
      3'd2: arp.axis_o_tdata = byteSwap32(OUR_MAC[47:16]);
      3'd3: arp.axis_o_tdata = {OUR_IP[23:16], OUR_IP[31:24], OUR_MAC[7:0], OUR_MAC[15:8]};
      3'd4: arp.axis_o_tdata = {16'h0000, OUR_IP[7:0], OUR_IP[15:8]};
      3'd5: arp.axis_o_tdata = 32'h00000000;
      3'd6: arp.axis_o_tdata = byteSwap32(target_q);
      default: arp.axis_o_tdata = '0;
    endcase
  end

endmodule

// File: tb/tb_arp_requester.sv
// Self-checking bench for arp_requester.
// Expected request packets and reply outcomes are derived from octet lists
// built field by field; captured output beats are compared against them.
module tb_arp_requester;

  localparam int          TO      = 100;
  localparam int          MR      = 2;
  localparam logic [47:0] OUR_MAC = 48'h070605040302;
  localparam logic [31:0] OUR_IP  = {8'd110, 8'd0, 8'd0, 8'd10};

  logic clk = 1'b0;
  logic sreset = 1'b1;

  arp_requester_if arp ();

  arp_requester #(
    .AXIS_BYTES(4), .OUR_MAC(OUR_MAC), .OUR_IP(OUR_IP),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .sreset(sreset), .arp(arp)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;
  int pktCount  = 0;
  bit bpMode    = 1'b0;

  logic [36:0] curBeats[$];
  logic [36:0] doneBeats[$];
  logic        stallPrev = 1'b0;
  logic [32:0] stallBeat;

  logic [31:0] target;
  logic [47:0] sha, sha2;
  int          startPkts;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Output stream monitor: collects accepted beats, checks stall stability
  always @(negedge clk) begin
    if (sreset) begin
      curBeats.delete();
      stallPrev = 1'b0;
    end else begin
      if (stallPrev)
        checkOutput("stall_hold", {arp.axis_o_tvalid, arp.axis_o_tlast, arp.axis_o_tdata},
                    {1'b1, stallBeat});
      if (arp.axis_o_tvalid && arp.axis_o_tready) begin
        curBeats.push_back({arp.axis_o_tlast, arp.axis_o_tkeep, arp.axis_o_tdata});
        if (arp.axis_o_tlast) begin
          doneBeats = curBeats;
          curBeats.delete();
          pktCount++;
        end
      end
      stallPrev = arp.axis_o_tvalid && !arp.axis_o_tready;
      stallBeat = {arp.axis_o_tlast, arp.axis_o_tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bpMode) arp.axis_o_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [31:0] ip);
    arp.req_valid = 1'b1;
    arp.req_ip    = ip;
    tick();
    arp.req_valid = 1'b0;
  endtask

  task automatic ackResp();
    arp.resp_ready = 1'b1;
    tick();
    arp.resp_ready = 1'b0;
  endtask

  task automatic waitPackets(input int n, input int bound, input string tag);
    int c = 0;
    while (pktCount < n && c < bound) begin
      tick();
      c++;
    end
    checkOutput(tag, 64'(pktCount >= n), 64'd1);
  endtask

  task automatic waitResp(input int bound, input string tag);
    int c = 0;
    while (!arp.resp_valid && c < bound) begin
      tick();
      c++;
    end
    checkOutput(tag, 64'(arp.resp_valid), 64'd1);
  endtask

  // Expected request: 28 octets in wire order, packed 4 per beat, first in [7:0]
  task automatic checkPacket(input logic [31:0] tgt, input string tag);
    logic [7:0]  b[28];
    logic [31:0] word;
    b[0] = 8'h00; b[1] = 8'h01; b[2] = 8'h08; b[3] = 8'h00;
    b[4] = 8'h06; b[5] = 8'h04; b[6] = 8'h00; b[7] = 8'h01;
    for (int i = 0; i < 6; i++) b[8 + i]  = OUR_MAC[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) b[14 + i] = OUR_IP[31 - 8*i -: 8];
    for (int i = 18; i < 24; i++) b[i] = 8'h00;
    for (int i = 0; i < 4; i++) b[24 + i] = tgt[31 - 8*i -: 8];
    checkOutput({tag, "_len"}, 64'(doneBeats.size()), 64'd7);
    for (int i = 0; i < 7; i++) begin
      word = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
      if (i < doneBeats.size())
        checkOutput($sformatf("%s_beat%0d", tag, i), 64'(doneBeats[i]),
                    64'({(i == 6), 4'hF, word}));
    end
  endtask

  // Drive one reply; octets beyond the 28-byte ARP body are zero padding
  task automatic sendReply(input logic [47:0] s, input logic [31:0] spa,
                           input logic [31:0] tpa, input logic [15:0] oper,
                           input int nBeats);
    logic [7:0] b[40];
    for (int i = 0; i < 40; i++) b[i] = 8'h00;
    b[0] = 8'h00; b[1] = 8'h01; b[2] = 8'h08; b[3] = 8'h00;
    b[4] = 8'h06; b[5] = 8'h04; b[6] = oper[15:8]; b[7] = oper[7:0];
    for (int i = 0; i < 6; i++) b[8 + i]  = s[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) b[14 + i] = spa[31 - 8*i -: 8];
    for (int i = 0; i < 6; i++) b[18 + i] = OUR_MAC[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) b[24 + i] = tpa[31 - 8*i -: 8];
    for (int i = 0; i < nBeats; i++) begin
      arp.axis_i_tvalid = 1'b1;
      arp.axis_i_tkeep  = 4'hF;
      arp.axis_i_tdata  = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
      arp.axis_i_tlast  = (i == nBeats - 1);
      tick();
    end
    arp.axis_i_tvalid = 1'b0;
    arp.axis_i_tlast  = 1'b0;
  endtask

  function automatic logic replyResolves(input logic [15:0] oper, input logic [31:0] spa,
                                         input logic [31:0] tpa, input int nBeats,
                                         input logic [31:0] tgt);
    return (oper == 16'd2) && (spa == tgt) && (tpa == OUR_IP) && (nBeats >= 7);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    arp.req_valid     = 1'b0;
    arp.req_ip        = '0;
    arp.resp_ready    = 1'b0;
    arp.axis_o_tready = 1'b1;
    arp.axis_i_tvalid = 1'b0;
    arp.axis_i_tlast  = 1'b0;
    arp.axis_i_tkeep  = 4'h0;
    arp.axis_i_tdata  = '0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_req_ready", 64'(arp.req_ready), 64'd1);
    checkOutput("rst_resp_valid", 64'(arp.resp_valid), 64'd0);
    checkOutput("rst_resp_ok", 64'(arp.resp_ok), 64'd0);
    checkOutput("rst_resp_ip", 64'(arp.resp_ip), 64'd0);
    checkOutput("rst_resp_mac", 64'(arp.resp_mac), 64'd0);
    checkOutput("rst_tvalid", 64'(arp.axis_o_tvalid), 64'd0);
    checkOutput("rst_i_tready", 64'(arp.axis_i_tready), 64'd1);
    checkOutput("dst_mac", 64'(arp.axis_o_dst_mac), 64'hFFFFFFFFFFFF);
    sreset = 1'b0;
    tick();

    // Basic resolution of 110.0.0.20
    target = {8'd110, 8'd0, 8'd0, 8'd20};
    applyStimulus(target);
    waitPackets(1, 40, "basic_pkt_wait");
    checkPacket(target, "basic");
    checkOutput("basic_beat0_lit", 64'(doneBeats[0][31:0]), 64'h00080100);
    checkOutput("basic_beat1_lit", 64'(doneBeats[1][31:0]), 64'h01000406);
    checkOutput("basic_beat6_lit", 64'(doneBeats[6][31:0]), 64'h1400006E);
    checkOutput("basic_tvalid_drop", 64'(arp.axis_o_tvalid), 64'd0);
    sendReply(48'h0A0B0C0D0E0F, target, OUR_IP, 16'd2, 7);
    checkOutput("basic_resp_valid", 64'(arp.resp_valid), 64'd1);
    checkOutput("basic_resp_ok", 64'(arp.resp_ok), 64'd1);
    checkOutput("basic_resp_mac", 64'(arp.resp_mac), 64'h0A0B0C0D0E0F);
    checkOutput("basic_resp_ip", 64'(arp.resp_ip), 64'(target));
    repeat (3) tick();
    checkOutput("basic_resp_hold", 64'(arp.resp_valid), 64'd1);
    ackResp();
    checkOutput("basic_back_idle", 64'({arp.req_ready, arp.resp_valid}), 64'b10);

    // Backpressure on the request stream with a random target
    target = {8'd110, 8'($urandom), 8'($urandom), 8'($urandom)};
    bpMode = 1'b1;
    applyStimulus(target);
    waitPackets(2, 200, "bp_pkt_wait");
    checkPacket(target, "bp");
    bpMode = 1'b0;
    arp.axis_o_tready = 1'b1;
    sha = {16'($urandom), 32'($urandom)};
    sendReply(sha, target, OUR_IP, 16'd2, 7);
    checkOutput("bp_resp_ok", 64'({arp.resp_valid, arp.resp_ok}), 64'b11);
    checkOutput("bp_resp_mac", 64'(arp.resp_mac), 64'(sha));
    ackResp();

    // Filtering: four bad replies, then a padded good one, then a late one in DONE
    target = {8'd110, 8'($urandom), 8'($urandom), 8'($urandom)};
    applyStimulus(target);
    waitPackets(3, 40, "filt_pkt_wait");
    for (int k = 0; k < 4; k++) begin
      logic [31:0] spa, tpa;
      logic [15:0] oper;
      int          nb;
      spa  = target;
      tpa  = OUR_IP;
      oper = 16'd2;
      nb   = 7;
      case (k)
        0: spa  = target ^ {24'h0, 8'($urandom_range(1, 255))};
        1: oper = 16'd1;
        2: tpa  = {8'd110, 8'd0, 8'd0, 8'd11};
        default: nb = 5;
      endcase
      sendReply({16'($urandom), 32'($urandom)}, spa, tpa, oper, nb);
      tick();
      checkOutput($sformatf("filt_reject%0d", k), 64'(arp.resp_valid),
                  64'(replyResolves(oper, spa, tpa, nb, target)));
    end
    sha = {16'($urandom), 32'($urandom)};
    sendReply(sha, target, OUR_IP, 16'd2, 9);
    checkOutput("filt_good_valid", 64'({arp.resp_valid, arp.resp_ok}), 64'b11);
    checkOutput("filt_good_mac", 64'(arp.resp_mac), 64'(sha));
    sha2 = ~sha;
    sendReply(sha2, target, OUR_IP, 16'd2, 7);
    tick();
    checkOutput("done_late_mac", 64'(arp.resp_mac), 64'(sha));
    checkOutput("done_late_valid", 64'(arp.resp_valid), 64'd1);
    checkOutput("filt_no_retry", 64'(pktCount), 64'd3);
    ackResp();

    // Timeout: no reply, expect first request plus MR retries, then failure
    target = {8'd110, 8'($urandom), 8'($urandom), 8'($urandom)};
    startPkts = pktCount;
    applyStimulus(target);
    waitResp((MR + 1) * (TO + 20) + 50, "to_resp_wait");
    checkOutput("to_pkt_count", 64'(pktCount - startPkts), 64'(MR + 1));
    checkOutput("to_resp_ok", 64'(arp.resp_ok), 64'd0);
    checkOutput("to_resp_mac", 64'(arp.resp_mac), 64'd0);
    checkOutput("to_resp_ip", 64'(arp.resp_ip), 64'(target));
    ackResp();

    // Reset while waiting for a reply
    target = {8'd110, 8'($urandom), 8'($urandom), 8'($urandom)};
    startPkts = pktCount;
    applyStimulus(target);
    waitPackets(startPkts + 1, 40, "rstw_pkt_wait");
    repeat (5) tick();
    sreset = 1'b1;
    tick();
    sreset = 1'b0;
    checkOutput("rstw_idle", 64'({arp.req_ready, arp.resp_valid}), 64'b10);
    repeat (TO + 50) tick();
    checkOutput("rstw_no_retry", 64'(pktCount - startPkts), 64'd1);

    // A valid-looking reply arriving in IDLE is ignored
    sendReply({16'($urandom), 32'($urandom)}, target, OUR_IP, 16'd2, 7);
    tick();
    checkOutput("idle_late_reply", 64'({arp.req_ready, arp.resp_valid}), 64'b10);

    // Repeat lookup of an already resolved address
    target = {8'd110, 8'd0, 8'd0, 8'd20};
    startPkts = pktCount;
    applyStimulus(target);
    waitPackets(startPkts + 1, 40, "rep_pkt_wait1");
    sha = {16'($urandom), 32'($urandom)};
    sendReply(sha, target, OUR_IP, 16'd2, 7);
    checkOutput("rep_first_mac", 64'(arp.resp_mac), 64'(sha));
    ackResp();
    startPkts = pktCount;
    applyStimulus(target);
`ifdef ARP_REQUESTER_CACHE_EN
    checkOutput("cache_resp_valid", 64'({arp.resp_valid, arp.resp_ok}), 64'b11);
    checkOutput("cache_resp_mac", 64'(arp.resp_mac), 64'(sha));
    repeat (10) tick();
    checkOutput("cache_no_tx", 64'(pktCount - startPkts), 64'd0);
    ackResp();
`else
    waitPackets(startPkts + 1, 40, "nocache_retx");
    checkPacket(target, "nocache");
    sreset = 1'b1;
    tick();
    sreset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
